// File: rtl/key_step_pkg.sv
// Shared state encodings and default timing constants for the step-key conditioner.
// Default constants target the 50 MHz DE2 board clock.
package key_step_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 12500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so an idle-high input resets to its idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_step_conditioner.sv
// Debounces the active-low step key into a one-cycle Step pulse and syncs Run.
// Optional auto-repeat while held: define STEP_AUTOREPEAT_EN.
module key_step_conditioner
    import key_step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
`ifdef STEP_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KEY_n,
    input  logic       SW_run,
    output logic       Step,
    output logic       Pressed,
    output logic       Run_sync,
    output logic [7:0] Step_count
);

    logic key_sync;
    logic key_s;

    sync_2ff #(.RST_VAL(1'b1)) u_key_sync (
        .clk_i (Clock),
        .rst_i (Reset),
        .d_i   (KEY_n),
        .q_o   (key_sync)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_run_sync (
        .clk_i (Clock),
        .rst_i (Reset),
        .d_i   (SW_run),
        .q_o   (Run_sync)
    );

    assign key_s = ~key_sync;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             pressed_q, pressed_d;
    logic [7:0]       count_q, count_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

`ifdef STEP_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (key_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                if (key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
`ifdef STEP_AUTOREPEAT_EN
        // Repeat phase pauses through release chatter; only a full release clears it
        rep_d = rep_q;
        if (state_q == HELD && key_s) begin
            if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
                rep_d  = '0;
                step_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
        if (state_d == RELEASED) begin
            rep_d = '0;
        end
`endif
        pressed_d = (state_d == HELD) || (state_d == RELEASE_CHK);
        count_d   = count_q + {7'd0, step_d};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
            count_q   <= '0;
`ifdef STEP_AUTOREPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            pressed_q <= pressed_d;
            count_q   <= count_d;
`ifdef STEP_AUTOREPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign Step       = step_q;
    assign Pressed    = pressed_q;
    assign Step_count = count_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Randomized and directed bench for key_step_conditioner against a run-length debounce model.
// Covers STEP_AUTOREPEAT_EN when that macro is defined for the build.
module tb_key_step_conditioner;

    localparam int D = 4;
    localparam int R = 10;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       KEY_n;
    logic       SW_run;
    logic       Step;
    logic       Pressed;
    logic       Run_sync;
    logic [7:0] Step_count;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    key_step_conditioner #(
        .DEBOUNCE_CYCLES(D)
`ifdef STEP_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES(R)
`endif
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .KEY_n      (KEY_n),
        .SW_run     (SW_run),
        .Step       (Step),
        .Pressed    (Pressed),
        .Run_sync   (Run_sync),
        .Step_count (Step_count)
    );

    // Reference model: delay lines for the synchronizers plus a run-length
    // count of samples disagreeing with the last accepted key level.
    bit m_k1, m_k2, m_s1, m_s2;
    bit m_stable;
    bit m_step;
    int m_run;
    int m_cnt;
`ifdef STEP_AUTOREPEAT_EN
    int m_rep;
`endif
    int steps_seen;
    bit cur_sw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k1 = 1'b1;
        m_k2 = 1'b1;
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_stable = 1'b0;
        m_step = 1'b0;
        m_run = 0;
        m_cnt = 0;
`ifdef STEP_AUTOREPEAT_EN
        m_rep = 0;
`endif
    endtask

    task automatic model_edge(input bit key, input bit sw);
        bit s;
        s = !m_k2;
        m_k2 = m_k1;
        m_k1 = key;
        m_s2 = m_s1;
        m_s1 = sw;
        m_step = 1'b0;
`ifdef STEP_AUTOREPEAT_EN
        if (m_stable && m_run == 0 && s) begin
            m_rep++;
            if (m_rep == R) begin
                m_rep = 0;
                m_step = 1'b1;
            end
        end
`endif
        if (s != m_stable) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            m_stable = s;
            m_run = 0;
            if (s) m_step = 1'b1;
`ifdef STEP_AUTOREPEAT_EN
            m_rep = 0;
`endif
        end
        if (m_step) m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic tick(input bit key, input bit sw);
        KEY_n = key;
        SW_run = sw;
        cur_sw = sw;
        @(posedge Clock);
        model_edge(key, sw);
        #1;
        if (Step === 1'b1) steps_seen++;
        check("step", 32'(Step), 32'(m_step));
        check("pressed", 32'(Pressed), 32'(m_stable));
        check("count", 32'(Step_count), m_cnt);
        check("run_sync", 32'(Run_sync), 32'(m_s2));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("rst_step", 32'(Step), 0);
        check("rst_pressed", 32'(Pressed), 0);
        check("rst_count", 32'(Step_count), 0);
        check("rst_run", 32'(Run_sync), 0);
        @(posedge Clock);
        #1;
        model_reset();
        Reset = 1'b0;
    endtask

    task automatic press_measure(input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1'b0, cur_sw);
            if (!found && Step === 1'b1) begin
                found = 1'b1;
                check(tag, i + 1, D + 3);
            end
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int base;
        Reset = 1'b1;
        KEY_n = 1'b1;
        SW_run = 1'b0;
        cur_sw = 1'b0;
        steps_seen = 0;
        model_reset();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);

        // clean press with latency measurement
        base = steps_seen;
        press_measure(20, "latency");
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        check("clean_steps", steps_seen - base, 1);
        check("clean_count", 32'(Step_count), 1);

        // short bounces never accepted
        base = steps_seen;
        tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        check("bounce_steps", steps_seen - base, 0);

        // release chatter yields a single step
        base = steps_seen;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        check("relbounce_steps", steps_seen - base, 1);
        check("relbounce_released", 32'(Pressed), 0);

        // Run switch through the synchronizer
        tick(1'b1, 1'b1);
        check("run_1edge", 32'(Run_sync), 0);
        tick(1'b1, 1'b1);
        check("run_2edge", 32'(Run_sync), 1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);

        // counter wrap
        do_reset();
        base = steps_seen;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
            for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
            if (p == 254) check("wrap_255", 32'(Step_count), 255);
        end
        check("wrap_0", 32'(Step_count), 0);
        check("wrap_steps", steps_seen - base, 256);

`ifdef STEP_AUTOREPEAT_EN
        base = steps_seen;
        press_measure(D + 3 + 35, "ar_latency");
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        check("autorepeat_steps", steps_seen - base, 4);
`endif

        // random key and switch activity
        for (int ph = 0; ph < 400; ph++) begin
            bit k;
            bit sw;
            int len;
            k = 1'($urandom_range(0, 1));
            sw = ($urandom_range(0, 7) == 0) ? ~cur_sw : cur_sw;
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++) tick(k, sw);
        end
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);

        // asynchronous reset during PRESS_CHK, key held across release
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        check("pre_reset_count_nonzero", 32'(Step_count != 8'd0), 1);
        do_reset();
        base = steps_seen;
        press_measure(20, "reset_held_latency");
        check("reset_held_steps", steps_seen - base, 1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
